// File: rtl/imp_var_unit.sv
// imp_var_unit: buffers N signed samples, waits for their mean, then outputs the
// population variance (1/N)*sum((x-Ex)^2) with the divide done as a floor shift.
module imp_var_unit #(
  parameter int N = 8,
  localparam int CNT_W = $clog2(N),
  localparam int EX_W = 9 + CNT_W,
  localparam int VAR_W = 2 * (EX_W + 1)
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  input  logic signed [8:0]      i_x,
  input  logic                   i_Ex_done,
  input  logic signed [EX_W-1:0] i_Ex,
  output logic                   o_ready,
  output logic                   o_var_done,
  output logic [VAR_W-1:0]       o_var
);
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_EX, SQ, DONE} state_t;
  state_t state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic signed [8:0] smp [N];
  logic [VAR_W+CNT_W-1:0] acc, acc_nxt;
  logic ex_flag;
  logic signed [EX_W-1:0] ex_reg;
  logic signed [EX_W:0] diff;
  logic signed [VAR_W-1:0] dx;
  logic [VAR_W-1:0] sq;
  logic last, take, ex_ld;
  assign last = cnt == CNT_W'(N - 1);
  assign take = i_valid && (state == IDLE || state == LOAD);
  assign ex_ld = i_Ex_done && (state == LOAD || state == WAIT_EX);
  assign diff = (EX_W+1)'(smp[cnt]) - (EX_W+1)'(ex_reg);
  assign dx = VAR_W'(diff);
  // |diff| stays far below 2^(VAR_W/2), so the low VAR_W bits hold the exact square
  assign sq = dx * dx;
  assign acc_nxt = acc + {{CNT_W{1'b0}}, sq};
  always_ff @(posedge i_clk)
    state <= i_rst ? IDLE : state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    state_nxt = i_valid ? LOAD : IDLE;
      LOAD:    state_nxt = (i_valid && last) ? WAIT_EX : LOAD;
      WAIT_EX: state_nxt = (ex_flag || i_Ex_done) ? SQ : WAIT_EX;
      SQ:      state_nxt = last ? DONE : SQ;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    o_ready = state == IDLE || state == LOAD;
    o_var_done = state == DONE;
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt <= '0;
      acc <= '0;
      ex_flag <= 1'b0;
      ex_reg <= '0;
      o_var <= '0;
    end else begin
      if (take || state == SQ) cnt <= (state == IDLE) ? CNT_W'(1) : cnt + CNT_W'(1);
      acc <= (state == IDLE) ? '0 : (state == SQ) ? acc_nxt : acc;
      ex_flag <= (state == IDLE) ? 1'b0 : ex_flag | ex_ld;
      if (ex_ld) ex_reg <= i_Ex;
      if (state == SQ && last) o_var <= acc_nxt[VAR_W+CNT_W-1:CNT_W];
    end
  end
  always_ff @(posedge i_clk)
    if (take) smp[(state == IDLE) ? '0 : cnt] <= i_x;
endmodule

// File: tb/tb_imp_var_unit.sv
// tb_imp_var_unit: directed vectors against a sum-of-squares reference model.
module tb_imp_var_unit;
  localparam int N = 8;
  localparam int EX_W = 12;
  localparam int VAR_W = 26;
  typedef int vec_t [8];
  logic clk = 1'b0;
  logic i_rst = 1'b1, i_valid = 1'b0, i_Ex_done = 1'b0;
  logic signed [8:0] i_x = '0;
  logic signed [EX_W-1:0] i_Ex = '0;
  logic o_ready, o_var_done;
  logic [VAR_W-1:0] o_var;
  int checks = 0, failures = 0;
  int cyc = 0;
  int done_at = -1;
  longint exp_pend = 0, exp_hold = 0;
  bit armed = 1'b0;

  imp_var_unit #(.N(N)) dut (
    .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .i_x(i_x),
    .i_Ex_done(i_Ex_done), .i_Ex(i_Ex), .o_ready(o_ready),
    .o_var_done(o_var_done), .o_var(o_var)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
    end
  endtask

  function automatic longint var_of(input vec_t xs, input int ex);
    longint s = 0;
    for (int i = 0; i < N; i++) s += longint'(xs[i] - ex) * longint'(xs[i] - ex);
    return s / N;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // mode 0: strobe Ex after wt cycles in WAIT_EX; 1: strobe Ex early during LOAD;
  // 2: early strobe with a wrong mean, then the right mean in the first WAIT_EX cycle
  task automatic run_vec(input vec_t xs, input int ex, input int gap, input int mode,
                         input int wt, input longint lit, input bit noise);
    int last_c, dn;
    for (int i = 0; i < N; i++) begin
      step();
      chk("ready_load", o_ready, 1);
      i_valid = 1'b1;
      i_x = 9'(xs[i]);
      i_Ex_done = 1'b0;
      last_c = cyc;
      if (i == 2 && mode != 0) begin
        step();
        i_valid = 1'b0;
        i_Ex_done = 1'b1;
        i_Ex = EX_W'(mode == 1 ? ex : 100);
      end
      if (i < N - 1)
        for (int g = 0; g < gap; g++) begin
          step();
          i_valid = 1'b0;
          i_Ex_done = 1'b0;
        end
    end
    step();
    i_valid = 1'b0;
    i_Ex_done = 1'b0;
    chk("ready_wait", o_ready, 0);
    if (mode == 0) begin
      for (int w = 0; w < wt; w++) begin
        step();
        chk("ready_wait", o_ready, 0);
      end
      i_Ex_done = 1'b1;
      i_Ex = EX_W'(ex);
      dn = cyc + N + 1;
    end else begin
      if (mode == 2) begin
        i_Ex_done = 1'b1;
        i_Ex = EX_W'(ex);
      end
      dn = last_c + N + 2;
    end
    exp_pend = var_of(xs, ex);
    done_at = dn;
    while (cyc < dn) begin
      step();
      i_Ex_done = 1'b0;
      i_valid = noise ? 1'($urandom_range(1)) : 1'b0;
      i_x = 9'($urandom_range(511));
      chk("ready_busy", o_ready, 0);
    end
    i_valid = 1'b0;
    chk("var_literal", o_var, lit);
    chk("done_literal", o_var_done, 1);
  endtask

  always @(negedge clk)
    if (armed) begin
      if (cyc == done_at) exp_hold = exp_pend;
      chk("done_strobe", o_var_done, cyc == done_at);
      chk("var_hold", o_var, exp_hold);
    end

  initial begin
    vec_t v1, v5, valt, vneg;
    v1 = '{1, 2, 3, 4, 5, 6, 7, 8};
    v5 = '{5, 5, 5, 5, 5, 5, 5, 5};
    valt = '{-256, 255, -256, 255, -256, 255, -256, 255};
    vneg = '{-8, -6, -4, -2, 0, 2, 4, 6};
    step();
    step();
    i_rst = 1'b0;
    chk("rst_var", o_var, 0);
    chk("rst_ready", o_ready, 1);
    chk("rst_done", o_var_done, 0);
    armed = 1'b1;
    run_vec(v1, 4, 0, 0, 0, 5, 1'b0);
    step();
    i_Ex_done = 1'b1;
    i_Ex = EX_W'(77);
    step();
    i_Ex_done = 1'b0;
    run_vec(v5, 5, 0, 0, 3, 0, 1'b0);
    run_vec(valt, 0, 0, 0, 1, 65280, 1'b0);
    run_vec(v1, 4, 2, 1, 0, 5, 1'b1);
    run_vec(vneg, -1, 1, 2, 0, 21, 1'b1);
    for (int i = 0; i < N; i++) begin
      step();
      i_valid = 1'b1;
      i_x = 9'(valt[i]);
    end
    step();
    i_valid = 1'b0;
    i_Ex_done = 1'b1;
    i_Ex = EX_W'(3);
    repeat (4) begin
      step();
      i_Ex_done = 1'b0;
    end
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    exp_hold = 0;
    done_at = -1;
    chk("midrst_var", o_var, 0);
    chk("midrst_done", o_var_done, 0);
    chk("midrst_ready", o_ready, 1);
    run_vec(v1, 4, 0, 0, 2, 5, 1'b0);
    run_vec(valt, 0, 0, 0, 0, 65280, 1'b0);
    run_vec(v1, 4, 0, 0, 0, 5, 1'b0);
    step();
    chk("idle_ready", o_ready, 1);
    armed = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not complete, checks=%0d", checks);
    $fatal(1, "timeout");
  end
endmodule
